// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
// Holds the FSM state encoding, BCD digit limits, the digit bundle
// type, board-rate defaults and the BCD increment helpers.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] MIN_T_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // 50 MHz board clock: one counted second, 20 ms key settle time
    localparam int TICK_DIV_DEF        = 50_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    // Ripple-carry BCD increment; 59:59 rolls over to 00:00
    function automatic bcd_time_t bcd_inc(input bcd_time_t t);
        bcd_time_t n;
        n = t;
        if (t.sec_u != DIGIT_MAX) begin
            n.sec_u = t.sec_u + 4'd1;
        end else begin
            n.sec_u = 4'd0;
            if (t.sec_t != SEC_T_MAX) begin
                n.sec_t = t.sec_t + 4'd1;
            end else begin
                n.sec_t = 4'd0;
                if (t.min_u != DIGIT_MAX) begin
                    n.min_u = t.min_u + 4'd1;
                end else begin
                    n.min_u = 4'd0;
                    if (t.min_t != MIN_T_MAX)
                        n.min_t = t.min_t + 4'd1;
                    else
                        n.min_t = 4'd0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic bcd_is_max(input bcd_time_t t);
        return (t.min_t == MIN_T_MAX) && (t.min_u == DIGIT_MAX) &&
               (t.sec_t == SEC_T_MAX) && (t.sec_u == DIGIT_MAX);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// One push-key front end: 2-FF synchroniser, debounce counter and a
// registered one-cycle press pulse on each accepted 1->0 level change.
// Ports:
//   clock, reset : rising-edge clock, async active-high reset
//   key_n        : raw active-low key
//   press        : one-cycle pulse, DEBOUNCE_CYCLES+3 cycles after
//                  a stable falling raw edge
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Synchronisers reset to the released level so that leaving reset
    // with the key up can never look like a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_d <= level;
            press   <= level_d & ~level;
            // A two-level input that changes while it differs from the
            // accepted level falls back onto it, so clearing here is the
            // restart-on-change rule.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencer: debounced clear/start keys, IDLE/RUN/PAUSE
// FSM, 1 Hz prescaler and four directly maintained BCD digits.
// Ports:
//   clock, reset      : rising-edge clock, async active-high reset
//   key[1:0]          : raw active-low keys, [0]=clear, [1]=start/stop
//   lap_n             : raw active-low lap key (LAP_HOLD_EN builds only)
//   digit_min_t/min_u : BCD minutes, digit_sec_t/sec_u : BCD seconds
//   running           : high while in RUN
//   tick, wrap        : one-cycle pulses per second / on 59:59->00:00
// Build option: define LAP_HOLD_EN to add the lap display hold.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV        = TICK_DIV_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] key,
`ifdef LAP_HOLD_EN
    input  logic       lap_n,
`endif
    output logic [3:0] digit_min_t,
    output logic [3:0] digit_min_u,
    output logic [3:0] digit_sec_t,
    output logic [3:0] digit_sec_u,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic          clr_press;
    logic          start_press;
    sw_state_t     state;
    logic [PW-1:0] pre;
    bcd_time_t     cnt;
    bcd_time_t     cnt_inc;
    logic          at_max;
    logic          step;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clr (
        .clock (clock),
        .reset (reset),
        .key_n (key[0]),
        .press (clr_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_start (
        .clock (clock),
        .reset (reset),
        .key_n (key[1]),
        .press (start_press)
    );

    always_comb begin
        step    = (state == RUN) && (pre == PRE_LAST);
        cnt_inc = bcd_inc(cnt);
        at_max  = bcd_is_max(cnt);
    end

    // Clear overrides everything, including a simultaneous start.
    // In RUN the prescaler advances before a start press is honoured,
    // so a terminal-count second is still counted on the way to PAUSE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= '0;
            cnt     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clr_press) begin
                state   <= IDLE;
                pre     <= '0;
                cnt     <= '0;
                running <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_press) begin
                            state   <= RUN;
                            pre     <= '0;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (step) begin
                            pre  <= '0;
                            tick <= 1'b1;
                            cnt  <= cnt_inc;
                            wrap <= at_max;
                        end else begin
                            pre <= pre + PW'(1);
                        end
                        if (start_press) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start_press) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic      lap_press;
    logic      hold;
    logic      hold_nx;
    bcd_time_t disp;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lap (
        .clock (clock),
        .reset (reset),
        .key_n (lap_n),
        .press (lap_press)
    );

    // Hold can only be entered from RUN; any start or clear drops it,
    // so PAUSE and IDLE never see a held display.
    always_comb begin
        hold_nx = hold;
        if (clr_press || start_press)
            hold_nx = 1'b0;
        else if (lap_press)
            hold_nx = hold ? 1'b0 : (state == RUN);
    end

    // The display tracks the count's next value so it stays in step
    // with tick when not held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold <= 1'b0;
            disp <= '0;
        end else begin
            hold <= hold_nx;
            if (clr_press)
                disp <= '0;
            else if (!hold_nx)
                disp <= step ? cnt_inc : cnt;
        end
    end

    assign digit_min_t = disp.min_t;
    assign digit_min_u = disp.min_u;
    assign digit_sec_t = disp.sec_t;
    assign digit_sec_u = disp.sec_u;
`else
    assign digit_min_t = cnt.min_t;
    assign digit_min_u = cnt.min_u;
    assign digit_sec_t = cnt.sec_t;
    assign digit_sec_u = cnt.sec_u;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Cycle numbers below are posedge counts; checks run on the negedge.
module tb_stopwatch_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] key   = 2'b11;
`ifdef LAP_HOLD_EN
    logic       lap_n = 1'b1;
`endif
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       running, tick, wrap;
    logic [15:0] digits;

    int n_pass    = 0;
    int n_total   = 0;
    int cyc       = 0;
    int tick_cnt  = 0;
    int last_tick = 0;
    int wrap_cnt  = 0;

    assign digits = {min_t, min_u, sec_t, sec_u};

    stopwatch_ctrl #(
        .TICK_DIV(4),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key         (key),
`ifdef LAP_HOLD_EN
        .lap_n       (lap_n),
`endif
        .digit_min_t (min_t),
        .digit_min_u (min_u),
        .digit_sec_t (sec_t),
        .digit_sec_u (sec_u),
        .running     (running),
        .tick        (tick),
        .wrap        (wrap)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        if (!reset) begin
            if (tick) begin
                tick_cnt++;
                last_tick = cyc;
            end
            if (wrap) wrap_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        m = s / 60;
        return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        key   = 2'b11;
        step(2);
        reset = 1'b0;
        step(2);
    endtask

    // start key low 6 cycles; returns the cycle RUN was entered
    task automatic press_start(output int rc);
        key[1] = 1'b0;
        step(6);
        key[1] = 1'b1;
        step(1);
        rc = cyc;
    endtask

    task automatic test_reset();
        step(2);
        n_total++;
        if (digits !== 16'h0000) $display("FAIL rst_digits: got %h want 0000", digits);
        else n_pass++;
        n_total++;
        if (running !== 1'b0) $display("FAIL rst_running: got %b want 0", running);
        else n_pass++;
        n_total++;
        if ({tick, wrap} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {tick, wrap});
        else n_pass++;
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_start();
        int rc, nt, prev, bad, first;
        nt = 0; prev = -1; bad = 0; first = -1;
        key[1] = 1'b0;
        step(6);
        key[1] = 1'b1;
        n_total++;
        if (running !== 1'b0) $display("FAIL start_early: got %b want 0", running);
        else n_pass++;
        step(1);
        rc = cyc;
        n_total++;
        if (running !== 1'b1) $display("FAIL start_run: got %b want 1", running);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (tick) begin
                nt++;
                if (first < 0) first = cyc - rc;
                if (prev >= 0 && cyc - prev != 4) bad++;
                prev = cyc;
            end
        end
        n_total++;
        if (nt != 10) $display("FAIL start_ticks: got %0d want 10", nt);
        else n_pass++;
        n_total++;
        if (first != 4 || bad != 0)
            $display("FAIL start_spacing: first %0d bad %0d want 4 0", first, bad);
        else n_pass++;
        n_total++;
        if (digits !== 16'h0010) $display("FAIL start_digits: got %h want 0010", digits);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rc;
        bit found;
        found = 0;
        do_reset();
        press_start(rc);
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (tick && digits == 16'h0007) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL rmid_reach: got no 0007 tick want 0007 tick");
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (digits !== 16'h0000) $display("FAIL rmid_digits: got %h want 0000", digits);
        else n_pass++;
        n_total++;
        if ({running, tick} !== 2'b00)
            $display("FAIL rmid_flags: got %b want 00", {running, tick});
        else n_pass++;
        step(2);
        reset = 1'b0;
        step(3);
    endtask

    task automatic test_bounce_pause();
        int c0, rc, t0;
        c0 = cyc;
        key[1] = 1'b0;
        step(1);
        key[1] = 1'b1;
        step(1);
        key[1] = 1'b0;
        go_to(c0 + 8);
        n_total++;
        if (running !== 1'b0) $display("FAIL bounce_early: got %b want 0", running);
        else n_pass++;
        go_to(c0 + 9);
        rc = cyc;
        t0 = tick_cnt;
        n_total++;
        if (running !== 1'b1) $display("FAIL bounce_run: got %b want 1", running);
        else n_pass++;
        go_to(rc + 1);
        key[1] = 1'b1;
        go_to(rc + 7);
        n_total++;
        if (running !== 1'b1) $display("FAIL held_repeat: got %b want 1", running);
        else n_pass++;
        key[1] = 1'b0;
        go_to(rc + 13);
        key[1] = 1'b1;
        go_to(rc + 14);
        n_total++;
        if (running !== 1'b0 || tick_cnt - t0 != 3 || digits !== 16'h0003)
            $display("FAIL pause: got run %b ticks %0d %h want 0 3 0003",
                     running, tick_cnt - t0, digits);
        else n_pass++;
        go_to(rc + 23);
        key[1] = 1'b0;
        go_to(rc + 29);
        key[1] = 1'b1;
        n_total++;
        if (tick_cnt - t0 != 3 || digits !== 16'h0003)
            $display("FAIL pause_hold: got ticks %0d %h want 3 0003",
                     tick_cnt - t0, digits);
        else n_pass++;
        go_to(rc + 31);
        n_total++;
        if (running !== 1'b1 || tick_cnt - t0 != 3)
            $display("FAIL resume: got run %b ticks %0d want 1 3",
                     running, tick_cnt - t0);
        else n_pass++;
        go_to(rc + 32);
        n_total++;
        if (tick !== 1'b1 || last_tick != rc + 32 || digits !== 16'h0004)
            $display("FAIL resume_tick: got tick %b at %0d %h want 1 at %0d 0004",
                     tick, last_tick - rc, digits, 32);
        else n_pass++;
        go_to(rc + 37);
        key[1] = 1'b0;
        go_to(rc + 43);
        key[1] = 1'b1;
        go_to(rc + 44);
        n_total++;
        if (tick !== 1'b1 || digits !== 16'h0007 || running !== 1'b0)
            $display("FAIL tc_pause: got tick %b %h run %b want 1 0007 0",
                     tick, digits, running);
        else n_pass++;
        step(8);
        n_total++;
        if (tick_cnt - t0 != 7 || digits !== 16'h0007)
            $display("FAIL tc_hold: got ticks %0d %h want 7 0007",
                     tick_cnt - t0, digits);
        else n_pass++;
    endtask

    task automatic test_clear_both();
        int r, c;
        step(4);
        press_start(r);
        go_to(r + 12);
        n_total++;
        if (digits !== 16'h0010 || tick !== 1'b1)
            $display("FAIL resume_tc: got %h tick %b want 0010 1", digits, tick);
        else n_pass++;
        step(2);
        c = cyc;
        key = 2'b00;
        step(6);
        key = 2'b11;
        n_total++;
        if (running !== 1'b1) $display("FAIL both_early: got %b want 1", running);
        else n_pass++;
        go_to(c + 7);
        n_total++;
        if (running !== 1'b0 || digits !== 16'h0000)
            $display("FAIL both_clear: got run %b %h want 0 0000", running, digits);
        else n_pass++;
        step(12);
        n_total++;
        if (running !== 1'b0 || digits !== 16'h0000)
            $display("FAIL both_stay: got run %b %h want 0 0000", running, digits);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int r, model, bad, w0;
        bit found, got;
        model = 0; bad = 0; found = 0;
        w0 = wrap_cnt;
        press_start(r);
        for (int i = 0; i < 20000 && !found; i++) begin
            step(1);
            if (tick) begin
                model++;
                if (digits !== to_bcd(model)) bad++;
                if (model == 3598) found = 1;
            end
        end
        n_total++;
        if (!found || digits !== 16'h5958)
            $display("FAIL wrap_reach: got %h want 5958", digits);
        else n_pass++;
        n_total++;
        if (bad != 0 || wrap_cnt != w0)
            $display("FAIL count_seq: got bad %0d wraps %0d want 0 0",
                     bad, wrap_cnt - w0);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin step(1); got = tick; end
        n_total++;
        if (!got || digits !== 16'h5959 || wrap !== 1'b0)
            $display("FAIL wrap_5959: got %h wrap %b want 5959 0", digits, wrap);
        else n_pass++;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin step(1); got = tick; end
        n_total++;
        if (!got || digits !== 16'h0000 || wrap !== 1'b1 || running !== 1'b1)
            $display("FAIL wrap_roll: got %h wrap %b run %b want 0000 1 1",
                     digits, wrap, running);
        else n_pass++;
        step(1);
        n_total++;
        if (wrap !== 1'b0) $display("FAIL wrap_pulse: got %b want 0", wrap);
        else n_pass++;
    endtask

`ifdef LAP_HOLD_EN
    task automatic test_lap();
        int r, t2;
        bit found;
        found = 0;
        do_reset();
        press_start(r);
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (tick && digits == 16'h0002) found = 1;
        end
        t2 = cyc;
        lap_n = 1'b0;
        step(3);
        lap_n = 1'b1;
        step(3);
        lap_n = 1'b0;
        step(3);
        lap_n = 1'b1;
        go_to(t2 + 12);
        n_total++;
        if (!found || digits !== 16'h0003 || tick !== 1'b1)
            $display("FAIL lap_hold: got %h tick %b want 0003 1", digits, tick);
        else n_pass++;
        go_to(t2 + 13);
        n_total++;
        if (digits !== 16'h0005) $display("FAIL lap_release: got %h want 0005", digits);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_start();
        test_reset_mid();
        test_bounce_pause();
        test_clear_both();
        test_wrap();
`ifdef LAP_HOLD_EN
        test_lap();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
